// File: rtl/ex_hilo_muldiv.sv
// ex_hilo_muldiv: EX-stage HI/LO unit.
// Holds the architectural HI/LO registers. It handles single-cycle MULT/MULTU,
// MTHI/MTLO, and a 32-step restoring DIV/DIVU that holds the front end through
// stall_req until the result commits.
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   ex_A, ex_B             rs/rt operands (dividend/divisor, multiplicand/multiplier, MT data)
//   ex_mul, ex_div         multiply / divide request in EX
//   ex_signed              signed variant (MULT/DIV)
//   ex_whilo               [1] write HI, [0] write LO with ex_A
//   ex_rhilo               [1] read HI, else [0] read LO
//   flush                  kill the EX instruction, abort any divide
//   hilo_rdata             MFHI/MFLO read data
//   stall_req              freeze PC/IF/ID/ID-EX while the divider owns EX
//   hi, lo                 architectural HI/LO
module ex_hilo_muldiv #(
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] ex_A,
  input  logic [31:0] ex_B,
  input  logic        ex_mul,
  input  logic        ex_div,
  input  logic        ex_signed,
  input  logic [1:0]  ex_whilo,
  input  logic [1:0]  ex_rhilo,
  input  logic        flush,
  output logic [31:0] hilo_rdata,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;     // partial remainder
  logic [31:0] quot_q, quot_d;   // dividend shifts out as quotient shifts in
  logic [31:0] dvs_q, dvs_d;     // divisor magnitude
  logic        a_neg_q, a_neg_d;
  logic        b_neg_q, b_neg_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b;
  logic [63:0] mul_a, mul_b, prod;
  logic [33:0] trial;
  logic        borrow;
  logic [31:0] q_fix, r_fix;

  assign a_neg = ex_signed & ex_A[31];
  assign b_neg = ex_signed & ex_B[31];
  assign abs_a = a_neg ? -ex_A : ex_A;
  assign abs_b = b_neg ? -ex_B : ex_B;

  // Extending both operands to 64 bits and keeping the low 64 bits of the
  // product gives the correct signed or unsigned result.
  assign mul_a = ex_signed ? {{32{ex_A[31]}}, ex_A} : {32'd0, ex_A};
  assign mul_b = ex_signed ? {{32{ex_B[31]}}, ex_B} : {32'd0, ex_B};
  assign prod  = mul_a * mul_b;

  // One restoring step: {rem,quot} << 1, then trial-subtract the divisor.
  // The top bit of the trial result is the borrow.
  assign trial  = {rem_q, quot_q[31]} - {2'b00, dvs_q};
  assign borrow = trial[33];

  // The quotient is negative when the operand signs differ.
  // The remainder takes the sign of the dividend.
  // 0x80000000 / -1 wraps back to 0x80000000 naturally.
  assign q_fix = (a_neg_q ^ b_neg_q) ? -quot_q : quot_q;
  assign r_fix = a_neg_q ? -rem_q[31:0] : rem_q[31:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvs_d     = dvs_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    stall_req = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ex_div) begin
          stall_req = 1'b1;
          state_d   = S_BUSY;
          rem_d     = '0;
          quot_d    = abs_a;
          dvs_d     = abs_b;
          a_neg_d   = a_neg;
          b_neg_d   = b_neg;
          dz_d      = (ex_B == 32'd0);
          cnt_d     = '0;
        end else if (ex_mul) begin
          {hi_d, lo_d} = prod;
        end else begin
          if (ex_whilo[1]) hi_d = ex_A;
          if (ex_whilo[0]) lo_d = ex_A;
        end
      end
      S_BUSY: begin
        stall_req = 1'b1;
        rem_d     = borrow ? {rem_q[31:0], quot_q[31]} : trial[32:0];
        quot_d    = {quot_q[30:0], ~borrow};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'(DIV_ITERS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        // A divide by zero still takes the full latency, but it leaves HI/LO untouched.
        if (!dz_q) begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything: back to IDLE, no HI/LO write, and the pipeline is released.
    if (flush) begin
      state_d   = S_IDLE;
      hi_d      = hi_q;
      lo_d      = lo_q;
      stall_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvs_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvs_q   <= dvs_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
  assign hilo_rdata = ex_rhilo[1] ? hi_q : (ex_rhilo[0] ? lo_q : 32'd0);

endmodule

// File: tb/tb_ex_hilo_muldiv.sv
module tb_ex_hilo_muldiv;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] ex_A = '0, ex_B = '0;
  logic        ex_mul = 1'b0, ex_div = 1'b0, ex_signed = 1'b0, flush = 1'b0;
  logic [1:0]  ex_whilo = '0, ex_rhilo = '0;
  logic [31:0] hilo_rdata, hi, lo;
  logic        stall_req;

  ex_hilo_muldiv dut (
    .clk(clk), .resetn(resetn), .ex_A(ex_A), .ex_B(ex_B), .ex_mul(ex_mul),
    .ex_div(ex_div), .ex_signed(ex_signed), .ex_whilo(ex_whilo),
    .ex_rhilo(ex_rhilo), .flush(flush), .hilo_rdata(hilo_rdata),
    .stall_req(stall_req), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  localparam int K_MUL = 0, K_DIV = 1, K_WHL = 2;

  typedef struct {
    int          kind;
    bit          sgn;
    logic [31:0] a, b;
    logic [1:0]  whilo;
    logic [31:0] eh, el;
  } vec_t;

  vec_t        tbl[9];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] hi_m, lo_m;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model built from the architectural rules: plain 64-bit arithmetic.
  task automatic model(input int kind, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] whilo, inout logic [31:0] mh, inout logic [31:0] ml);
    longint s_a, s_b, s_q, s_r, s_p;
    longint unsigned u_a, u_b, u_q, u_r, u_p;
    if (kind == K_MUL) begin
      if (sgn) begin
        s_a = $signed(a); s_b = $signed(b); s_p = s_a * s_b;
        mh = s_p[63:32]; ml = s_p[31:0];
      end else begin
        u_a = a; u_b = b; u_p = u_a * u_b;
        mh = u_p[63:32]; ml = u_p[31:0];
      end
    end else if (kind == K_DIV) begin
      if (b != 0) begin
        if (sgn) begin
          s_a = $signed(a); s_b = $signed(b); s_q = s_a / s_b; s_r = s_a % s_b;
          mh = s_r[31:0]; ml = s_q[31:0];
        end else begin
          u_a = a; u_b = b; u_q = u_a / u_b; u_r = u_a % u_b;
          mh = u_r[31:0]; ml = u_q[31:0];
        end
      end
    end else begin
      if (whilo[1]) mh = a;
      if (whilo[0]) ml = a;
    end
  endtask

  task automatic check_regs(input string tag, input logic [31:0] eh, input logic [31:0] el);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    ex_rhilo = 2'b10; #1;
    chk({tag, "_mfhi"}, hilo_rdata, eh);
    ex_rhilo = 2'b01; #1;
    chk({tag, "_mflo"}, hilo_rdata, el);
    ex_rhilo = 2'b00;
  endtask

  task automatic apply_op(input string tag, input int kind, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [1:0] whilo,
                          input logic [31:0] eh, input logic [31:0] el);
    int n;
    ex_A = a; ex_B = b; ex_signed = sgn;
    if (kind == K_DIV) begin
      ex_div = 1'b1; #2;
      n = 0;
      while (stall_req && n < 40) begin n++; step(); #1; end
      chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
      // DONE with ex_div still high: the divider must not restart.
      step();
      ex_div = 1'b0; #1;
      chk({tag, "_no_restart"}, {31'd0, stall_req}, 32'd0);
    end else begin
      if (kind == K_MUL) ex_mul = 1'b1;
      ex_whilo = whilo; #2;
      chk({tag, "_nostall"}, {31'd0, stall_req}, 32'd0);
      step();
      ex_mul = 1'b0; ex_whilo = 2'b00; #1;
    end
    ex_A = '0; ex_B = '0; ex_signed = 1'b0;
    check_regs(tag, eh, el);
  endtask

  initial begin
    logic [31:0] ra, rb, eh, el;
    int k;
    bit s;
    tbl[0] = '{K_DIV, 1'b0, 32'd100,       32'd7,         2'b00, 32'd2,         32'd14};
    tbl[1] = '{K_DIV, 1'b1, 32'hFFFFFFF9,  32'd2,         2'b00, 32'hFFFFFFFF,  32'hFFFFFFFD};
    tbl[2] = '{K_DIV, 1'b1, 32'h80000000,  32'hFFFFFFFF,  2'b00, 32'd0,         32'h80000000};
    tbl[3] = '{K_MUL, 1'b1, 32'hFFFFFFFF,  32'd2,         2'b00, 32'hFFFFFFFF,  32'hFFFFFFFE};
    tbl[4] = '{K_MUL, 1'b0, 32'hFFFFFFFF,  32'd2,         2'b00, 32'h00000001,  32'hFFFFFFFE};
    tbl[5] = '{K_WHL, 1'b0, 32'h00001234,  32'd0,         2'b10, 32'h00001234,  32'hFFFFFFFE};
    tbl[6] = '{K_DIV, 1'b1, 32'd55,        32'd0,         2'b00, 32'h00001234,  32'hFFFFFFFE};
    tbl[7] = '{K_WHL, 1'b0, 32'hA5A5A5A5,  32'd0,         2'b11, 32'hA5A5A5A5,  32'hA5A5A5A5};
    // mul takes priority over a simultaneous MT write
    tbl[8] = '{K_MUL, 1'b0, 32'h00010000,  32'h00010003,  2'b11, 32'h00000001,  32'h00030000};

    repeat (2) step();
    chk("reset_stall", {31'd0, stall_req}, 32'd0);
    check_regs("reset", 32'd0, 32'd0);
    chk("reset_rdata_none", hilo_rdata, 32'd0);
    resetn = 1'b1;
    step();

    foreach (tbl[i])
      apply_op($sformatf("vec%0d", i), tbl[i].kind, tbl[i].sgn, tbl[i].a, tbl[i].b,
               tbl[i].whilo, tbl[i].eh, tbl[i].el);
    hi_m = 32'hA5A5A5A5; lo_m = 32'hA5A5A5A5;
    model(K_MUL, 1'b0, 32'h00010000, 32'h00010003, 2'b11, hi_m, lo_m);

    // Flush in BUSY cycle 10: the pipeline is released at once and the result is dropped.
    model(K_WHL, 1'b0, 32'h0BADF00D, 32'd0, 2'b11, hi_m, lo_m);
    apply_op("pre_flush", K_WHL, 1'b0, 32'h0BADF00D, 32'd0, 2'b11, hi_m, lo_m);
    ex_div = 1'b1; ex_A = 32'd1000; ex_B = 32'd7; #1;
    chk("div_start_stall", {31'd0, stall_req}, 32'd1);
    repeat (10) step();
    flush = 1'b1; #1;
    chk("flush_stall", {31'd0, stall_req}, 32'd0);
    step();
    flush = 1'b0; ex_div = 1'b0; ex_A = '0; ex_B = '0; #1;
    chk("flush_idle", {31'd0, stall_req}, 32'd0);
    repeat (30) step();
    check_regs("flush_div", hi_m, lo_m);
    apply_op("divu_9_3", K_DIV, 1'b0, 32'd9, 32'd3, 2'b00, 32'd0, 32'd3);
    hi_m = 32'd0; lo_m = 32'd3;

    // Flushed MT and MULT writes are suppressed.
    ex_whilo = 2'b11; ex_A = 32'h12345678; flush = 1'b1;
    step();
    ex_whilo = 2'b00; ex_mul = 1'b1; ex_B = 32'd5;
    step();
    flush = 1'b0; ex_mul = 1'b0; ex_A = '0; ex_B = '0; #1;
    check_regs("flush_wr", hi_m, lo_m);

    // Randomized ops against the model.
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      s = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 17);
        2: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        default: ;
      endcase
      eh = hi_m; el = lo_m;
      model(k, s, ra, rb, 2'($urandom_range(1, 3)), eh, el);
      if (k == K_WHL) begin
        // Recover the MT bits the model consumed from the resulting change.
        apply_op($sformatf("rnd%0d", i), k, s, ra, rb,
                 {eh != hi_m || ra == hi_m, el != lo_m || ra == lo_m}, eh, el);
      end else begin
        apply_op($sformatf("rnd%0d", i), k, s, ra, rb, 2'b00, eh, el);
      end
      hi_m = eh; lo_m = el;
    end

    // Reset in the middle of a divide.
    ex_div = 1'b1; ex_A = 32'd50; ex_B = 32'd3;
    repeat (6) step();
    resetn = 1'b0; ex_div = 1'b0; ex_A = '0; ex_B = '0;
    step();
    chk("rst_mid_stall", {31'd0, stall_req}, 32'd0);
    check_regs("rst_mid", 32'd0, 32'd0);
    resetn = 1'b1;
    step(); #1;
    chk("rst_mid_idle", {31'd0, stall_req}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
